// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable width, oversampling, parity and stop bits.
// Frames are accepted over a valid/ready handshake and timed from a shared baud_tick.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx_busy,
  output logic                 tx_done_tick,
  output logic                 tx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_reg, state_next;
  logic [TW-1:0]        tick_reg, tick_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] word_reg, word_next;
  logic [1:0]           mode_reg, mode_next;
  logic                 stop2_reg, stop2_next;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;
  logic                 bit_end;
  logic                 parity_on;
  logic                 parity_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      word_reg  <= '0;
      mode_reg  <= 2'b00;
      stop2_reg <= 1'b0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      word_reg  <= word_next;
      mode_reg  <= mode_next;
      stop2_reg <= stop2_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
    end
  end

  // Parity is taken from the latched word so the shifting register cannot disturb it.
  assign parity_on  = (mode_reg == 2'b01) || (mode_reg == 2'b10);
  assign parity_bit = (mode_reg == 2'b10) ? ~^word_reg : ^word_reg;
  assign bit_end    = (state_reg != IDLE) && baud_tick && (tick_reg == LAST_TICK);

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    word_next  = word_reg;
    mode_next  = mode_reg;
    stop2_next = stop2_reg;
    done_next  = 1'b0;

    if (state_reg != IDLE && baud_tick)
      tick_next = bit_end ? '0 : tick_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          word_next  = tx_data;
          shift_next = tx_data;
          mode_next  = parity_mode;
          stop2_next = two_stop;
          tick_next  = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == LAST_BIT) begin
            bit_next   = '0;
            state_next = parity_on ? PARITY : STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      PARITY: if (bit_end) state_next = STOP;
      STOP: begin
        if (bit_end) begin
          if (stop2_reg && bit_reg == '0) begin
            bit_next = BW'(1);
          end else begin
            bit_next   = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx follows the state being entered so the line is registered without lagging a cycle.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_ready     = (state_reg == IDLE);
  assign tx_busy      = ~tx_ready;
  assign tx_done_tick = done_reg;
  assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: table of frames decoded from tx at mid-bit points,
// plus hand-written back-to-back and mid-frame reset sequences.
module tb_uart_tx_cfg;

  logic       clk, reset_n, baud_tick;
  logic       valid8, ready8, busy8, done8, tx8;
  logic [7:0] data8;
  logic       valid7, ready7, busy7, done7, tx7;
  logic [6:0] data7;
  logic [1:0] parity_mode;
  logic       two_stop;

  int vecs = 0;
  int errs = 0;
  logic tr [0:4095];

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [1:0] mode;
    logic       two;
    int         nbits;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t tbl [10];

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick),
    .tx_valid(valid8), .tx_ready(ready8), .tx_data(data8),
    .parity_mode(parity_mode), .two_stop(two_stop),
    .tx_busy(busy8), .tx_done_tick(done8), .tx(tx8)
  );

  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8)) dut7 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick),
    .tx_valid(valid7), .tx_ready(ready7), .tx_data(data7),
    .parity_mode(parity_mode), .two_stop(two_stop),
    .tx_busy(busy7), .tx_done_tick(done7), .tx(tx7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // baud_tick every 4 clocks
  initial begin
    int tcnt;
    tcnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % 4;
      baud_tick = (tcnt == 0);
    end
  end

  function automatic logic cur_tx(input int sel);
    return (sel != 0) ? tx7 : tx8;
  endfunction
  function automatic logic cur_done(input int sel);
    return (sel != 0) ? done7 : done8;
  endfunction
  function automatic logic cur_ready(input int sel);
    return (sel != 0) ? ready7 : ready8;
  endfunction
  function automatic logic cur_busy(input int sel);
    return (sel != 0) ? busy7 : busy8;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    vecs++;
    if (got < lo || got > hi) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic logic [15:0] decode(input int start, input int nbits, input int period);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < nbits; k++) r[k] = tr[start + k*period + period/2];
    return r;
  endfunction

  task automatic wait_ready(input int sel);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (cur_ready(sel)) return;
    end
    check("ready_timeout", 0, 1);
  endtask

  // Accept one word, then scramble all inputs to prove they were latched.
  task automatic start_frame(input int sel, input logic [7:0] data, input logic [1:0] mode,
                             input logic two);
    wait_ready(sel);
    @(posedge clk);
    #1;
    parity_mode = mode;
    two_stop    = two;
    if (sel != 0) begin data7 = data[6:0]; valid7 = 1'b1; end
    else          begin data8 = data;      valid8 = 1'b1; end
    @(posedge clk);
    #1;
    valid7 = 1'b0;
    valid8 = 1'b0;
    data7  = ~data[6:0];
    data8  = ~data;
    parity_mode = ~mode;
    two_stop    = ~two;
  endtask

  task automatic capture(input int sel, output int d);
    d = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      tr[i] = cur_tx(sel);
      if (i == 0) check("busy_in_frame", cur_busy(sel), 1);
      if (cur_done(sel)) begin
        d = i;
        return;
      end
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic run_frame(input vec_t v);
    int d, period, extra;
    period = (v.sel != 0) ? 32 : 64;
    start_frame(v.sel, v.data, v.mode, v.two);
    capture(v.sel, d);
    if (d >= 0) begin
      check("start_latency", tr[0], 0);
      check_range("frame_len", d, v.nbits*period - 4, v.nbits*period);
      check("frame_bits", decode(0, v.nbits, period), v.exp_bits);
      check("ready_at_done", cur_ready(v.sel), 1);
      extra = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (cur_done(v.sel)) extra++;
      end
      check("single_done", extra, 0);
    end
  endtask

  initial begin
    int d1, s2, d2, cnt;
    // frame bits are listed first-sent in bit 0: start, data LSB first, parity, stop(s)
    tbl[0] = '{0, 8'h55, 2'b00, 1'b0, 10, 16'h02AA};
    tbl[1] = '{0, 8'h03, 2'b01, 1'b0, 11, 16'h0406};
    tbl[2] = '{0, 8'h03, 2'b10, 1'b0, 11, 16'h0606};
    tbl[3] = '{0, 8'h07, 2'b01, 1'b0, 11, 16'h060E};
    tbl[4] = '{0, 8'h07, 2'b10, 1'b0, 11, 16'h040E};
    tbl[5] = '{0, 8'hA5, 2'b00, 1'b1, 11, 16'h074A};
    tbl[6] = '{0, 8'h03, 2'b11, 1'b0, 10, 16'h0206};
    tbl[7] = '{0, 8'hFF, 2'b01, 1'b0, 11, 16'h05FE};
    tbl[8] = '{1, 8'h7F, 2'b10, 1'b1, 11, 16'h06FE};
    tbl[9] = '{1, 8'h2A, 2'b01, 1'b0, 10, 16'h0354};

    reset_n = 1'b0;
    valid8 = 1'b0; valid7 = 1'b0;
    data8 = '0; data7 = '0;
    parity_mode = 2'b00; two_stop = 1'b0;
    #23;
    check("rst_tx8", tx8, 1);
    check("rst_ready8", ready8, 1);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_tx7", tx7, 1);
    check("rst_ready7", ready7, 1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 10; n++) run_frame(tbl[n]);

    // Back-to-back with tx_valid held high across both frames
    wait_ready(0);
    @(posedge clk);
    #1;
    parity_mode = 2'b00; two_stop = 1'b0;
    data8 = 8'h12; valid8 = 1'b1;
    @(posedge clk);
    #1;
    data8 = 8'h34;
    d1 = -1; s2 = -1; d2 = -1;
    for (int i = 0; i < 4000 && d2 < 0; i++) begin
      @(negedge clk);
      tr[i] = tx8;
      if (done8) begin
        if (d1 < 0) d1 = i;
        else        d2 = i;
      end
      if (d1 >= 0 && s2 < 0 && i > d1 && tx8 == 1'b0) begin
        s2 = i;
        valid8 = 1'b0;
      end
    end
    valid8 = 1'b0;
    if (d2 < 0 || s2 < 0) begin
      check("b2b_timeout", 0, 1);
    end else begin
      check("b2b_first", decode(0, 10, 64), 16'h0224);
      check_range("b2b_gap", s2 - d1, 1, 2);
      check("b2b_second", decode(s2, 10, 64), 16'h0268);
      repeat (10) @(negedge clk);
      check("b2b_idle_after", ready8, 1);
    end

    // Reset during data bit 3 of 0x07 (that bit is 0 on the line)
    start_frame(0, 8'h07, 2'b00, 1'b0);
    repeat (288) @(negedge clk);
    check("pre_reset_tx", tx8, 0);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", tx8, 1);
    check("mid_rst_ready", ready8, 1);
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (done8) cnt++;
    end
    check("no_done_after_rst", cnt, 0);
    run_frame(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
